// File: rtl/mult_16_signed_arbiter.sv
// Round-robin front end that shares one pipelined 16x16 signed multiplier among NREQ requesters.
// Optional result chaining (re-multiply product halves) is enabled with MULT_ARB_CHAIN_EN.
module mult_16_signed_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*16-1:0]        req_a,
  input  logic [NREQ*16-1:0]        req_b,
`ifdef MULT_ARB_CHAIN_EN
  input  logic [NREQ-1:0]           req_chain,
`endif
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [31:0]               rsp_c,
  output logic                      busy
);

  localparam int unsigned IdW = $clog2(NREQ);
  localparam int unsigned NSt = LAT - 1;

  // Stage 1 data holds {a, b}; later stages hold the product.
  logic [NSt:1]   st_valid_q, st_valid_d;
  logic [NSt:1]   st_chain_q, st_chain_d;
  logic [IdW-1:0] st_id_q   [1:NSt];
  logic [IdW-1:0] st_id_d   [1:NSt];
  logic [31:0]    st_data_q [1:NSt];
  logic [31:0]    st_data_d [1:NSt];

  logic           rsp_valid_q, rsp_valid_d;
  logic [IdW-1:0] rsp_id_q, rsp_id_d;
  logic [31:0]    rsp_c_q, rsp_c_d;
  logic           busy_q, busy_d;
  logic [IdW-1:0] ptr_q, ptr_d;

  logic           advance;
  logic           reinject;
  logic           accept;
  logic           gnt_found;
  logic [IdW-1:0] gnt_idx;
  logic [15:0]    gnt_a;
  logic [15:0]    gnt_b;
  logic           gnt_chain;
  logic [31:0]    prod1;
  logic           tail_valid;
  logic           tail_chain;
  logic [IdW-1:0] tail_id;
  logic [31:0]    tail_p;
  int unsigned    scan;

  assign advance = !rsp_valid_q || rsp_ready;

  // Round-robin scan starting at ptr, wrapping at NREQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan      = 0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      scan = 32'(ptr_q) + off;
      if (scan >= NREQ) scan = scan - NREQ;
      if (!gnt_found && req_valid[scan[IdW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan[IdW-1:0];
      end
    end
  end

  assign gnt_a = req_a[{gnt_idx, 4'h0} +: 16];
  assign gnt_b = req_b[{gnt_idx, 4'h0} +: 16];

`ifdef MULT_ARB_CHAIN_EN
  assign gnt_chain = req_chain[gnt_idx];
`else
  assign gnt_chain = 1'b0;
`endif

  // Sign-extended operands so the low 32 bits are the exact signed product.
  assign prod1 = {{16{st_data_q[1][31]}}, st_data_q[1][31:16]} *
                 {{16{st_data_q[1][15]}}, st_data_q[1][15:0]};

  assign tail_valid = st_valid_q[NSt];
  assign tail_chain = st_chain_q[NSt];
  assign tail_id    = st_id_q[NSt];
  assign tail_p     = (LAT == 2) ? prod1 : st_data_q[NSt];

`ifdef MULT_ARB_CHAIN_EN
  assign reinject = advance && tail_valid && tail_chain;
`else
  assign reinject = 1'b0;
`endif

  assign accept = gnt_found && advance && !reinject;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      if (32'(gnt_idx) == NREQ - 1) ptr_d = '0;
      else                          ptr_d = gnt_idx + 1'b1;
    end
  end

  always_comb begin
    st_valid_d  = st_valid_q;
    st_chain_d  = st_chain_q;
    st_id_d     = st_id_q;
    st_data_d   = st_data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_c_d     = rsp_c_q;
    if (advance) begin
      for (int k = 2; k <= int'(NSt); k++) begin
        st_valid_d[k] = st_valid_q[k-1];
        st_chain_d[k] = st_chain_q[k-1];
        st_id_d[k]    = st_id_q[k-1];
        st_data_d[k]  = (k == 2) ? prod1 : st_data_q[k-1];
      end
      if (reinject) begin
        st_valid_d[1] = 1'b1;
        st_chain_d[1] = 1'b0;
        st_id_d[1]    = tail_id;
        st_data_d[1]  = {tail_p[15:0], tail_p[31:16]};
      end else if (accept) begin
        st_valid_d[1] = 1'b1;
        st_chain_d[1] = gnt_chain;
        st_id_d[1]    = gnt_idx;
        st_data_d[1]  = {gnt_a, gnt_b};
      end else begin
        st_valid_d[1] = 1'b0;
        st_chain_d[1] = 1'b0;
      end
      // A first-pass chained entry leaves a bubble in the response register.
      rsp_valid_d = tail_valid && !tail_chain;
      if (tail_valid && !tail_chain) begin
        rsp_id_d = tail_id;
        rsp_c_d  = tail_p;
      end
    end
    busy_d = rsp_valid_d || (|st_valid_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_valid_q  <= '0;
      st_chain_q  <= '0;
      for (int k = 1; k <= int'(NSt); k++) begin
        st_id_q[k]   <= '0;
        st_data_q[k] <= '0;
      end
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_c_q     <= '0;
      busy_q      <= 1'b0;
      ptr_q       <= '0;
    end else begin
      st_valid_q  <= st_valid_d;
      st_chain_q  <= st_chain_d;
      for (int k = 1; k <= int'(NSt); k++) begin
        st_id_q[k]   <= st_id_d[k];
        st_data_q[k] <= st_data_d[k];
      end
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_c_q     <= rsp_c_d;
      busy_q      <= busy_d;
      ptr_q       <= ptr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_c     = rsp_c_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mult_16_signed_arbiter.sv
// Scoreboard bench for mult_16_signed_arbiter (NREQ=4, LAT=2); chain cases run with
// MULT_ARB_CHAIN_EN defined.
module tb_mult_16_signed_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
`ifdef MULT_ARB_CHAIN_EN
  logic [3:0]  req_chain = '0;
`endif
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_c;
  logic        busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] c;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   rsp_log[$];
  int   rsp_cycle[$];
  int   cyc = 0;
  int   n_acc = 0;
  int   n_rsp = 0;

  mult_16_signed_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
`ifdef MULT_ARB_CHAIN_EN
    .req_chain (req_chain),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_c     (rsp_c),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mul16(input logic [15:0] a, input logic [15:0] b);
    shortint sa;
    shortint sb16;
    int      x;
    int      y;
    sa   = a;
    sb16 = b;
    x    = sa;
    y    = sb16;
    return 32'(x * y);
  endfunction

  // Monitor: push expectations on acceptance, pop and compare on response handshake.
  always @(negedge clk) begin
    exp_t e;
    int   idx;
    cyc++;
    if (rst) begin
      sb.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        rsp_log.push_back(int'(rsp_id));
        rsp_cycle.push_back(cyc);
        n_rsp++;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_rsp id=%0d c=%h required no response", rsp_id, rsp_c);
        end else begin
          e = sb.pop_front();
          if (rsp_id !== e.id || rsp_c !== e.c) begin
            failures++;
            $display("FAIL rsp_data id=%0d c=%h required id=%0d c=%h", rsp_id, rsp_c, e.id, e.c);
          end
        end
      end
      if (req_ready != 4'b0000) begin
        checks++;
        if ($countones(req_ready) != 1) begin
          failures++;
          $display("FAIL ready_onehot got=%b required one-hot", req_ready);
        end
        idx = 0;
        for (int i = 0; i < 4; i++) if (req_ready[i]) idx = i;
        e.id = 2'(idx);
        e.c  = mul16(req_a[idx*16 +: 16], req_b[idx*16 +: 16]);
`ifdef MULT_ARB_CHAIN_EN
        if (req_chain[idx]) e.c = mul16(e.c[15:0], e.c[31:16]);
`endif
        sb.push_back(e);
        grant_log.push_back(idx);
        n_acc++;
      end
    end
  end

  task automatic test_reset;
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks += 5;
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b required 0", rsp_valid); end
    if (rsp_c !== 32'h0) begin failures++; $display("FAIL reset_rsp_c got=%h required 0", rsp_c); end
    if (rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp_id got=%0d required 0", rsp_id); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b required 0", busy); end
    if (req_ready !== 4'b0) begin failures++; $display("FAIL reset_req_ready got=%b required 0", req_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    req_a = '0;
    req_b = '0;
    req_a[15:0] = 16'h7FFF;
    req_b[15:0] = 16'h7FFF;
    req_valid = 4'b0001;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready got=%b required 0001", req_ready); end
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_early got=%b required 0", rsp_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    checks += 3;
    if (rsp_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b required 1", rsp_valid); end
    if (rsp_c !== 32'h3FFF0001) begin failures++; $display("FAIL single_c got=%h required 3fff0001", rsp_c); end
    if (rsp_id !== 2'd0) begin failures++; $display("FAIL single_id got=%0d required 0", rsp_id); end
    @(posedge clk); #1;
  endtask

  task automatic test_signs;
    logic [15:0] ta [3];
    logic [15:0] tb [3];
    logic [31:0] tc [3];
    bit          got;
    ta = '{16'hFFFF, 16'h8000, 16'h0003};
    tb = '{16'h8000, 16'h8000, 16'hFFFB};
    tc = '{32'h00008000, 32'h40000000, 32'hFFFFFFF1};
    for (int i = 0; i < 3; i++) begin
      req_a = '0;
      req_b = '0;
      req_a[(i+1)*16 +: 16] = ta[i];
      req_b[(i+1)*16 +: 16] = tb[i];
      req_valid = 4'(1 << (i + 1));
      @(negedge clk);
      checks++;
      if (req_ready !== 4'(1 << (i + 1))) begin
        failures++; $display("FAIL sign_ready case=%0d got=%b required %b", i, req_ready, 4'(1 << (i + 1)));
      end
      @(posedge clk); #1 req_valid = '0;
      got = 1'b0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (rsp_valid) begin got = 1'b1; break; end
      end
      checks += 3;
      if (!got) begin failures++; $display("FAIL sign_timeout case=%0d got=no response required response", i); end
      if (rsp_c !== tc[i]) begin failures++; $display("FAIL sign_c case=%0d got=%h required %h", i, rsp_c, tc[i]); end
      if (rsp_id !== 2'(i + 1)) begin failures++; $display("FAIL sign_id case=%0d got=%0d required %0d", i, rsp_id, i + 1); end
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) break;
    end
    checks++;
    if (busy !== 1'b0 || sb.size() != 0) begin
      failures++; $display("FAIL %s_drain busy=%b pending=%0d required idle", name, busy, sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fairness;
    test_reset();
    grant_log.delete();
    rsp_log.delete();
    rsp_cycle.delete();
    for (int c = 0; c < 8; c++) begin
      req_a = {$urandom(), $urandom()};
      req_b = {$urandom(), $urandom()};
      req_valid = 4'hF;
      @(posedge clk); #1;
    end
    req_valid = '0;
    drain("fair");
    checks += 2;
    if (grant_log.size() != 8) begin failures++; $display("FAIL fair_grants got=%0d required 8", grant_log.size()); end
    if (rsp_log.size() != 8) begin failures++; $display("FAIL fair_rsps got=%0d required 8", rsp_log.size()); end
    for (int i = 0; i < 8 && i < grant_log.size() && i < rsp_log.size(); i++) begin
      checks += 2;
      if (grant_log[i] != i % 4) begin
        failures++; $display("FAIL fair_grant_order slot=%0d got=%0d required %0d", i, grant_log[i], i % 4);
      end
      if (rsp_log[i] != i % 4) begin
        failures++; $display("FAIL fair_rsp_order slot=%0d got=%0d required %0d", i, rsp_log[i], i % 4);
      end
    end
    if (rsp_cycle.size() == 8) begin
      checks++;
      if (rsp_cycle[7] - rsp_cycle[0] != 7) begin
        failures++; $display("FAIL fair_throughput span=%0d required 7", rsp_cycle[7] - rsp_cycle[0]);
      end
    end
  endtask

  task automatic test_backpressure;
    test_reset();
    n_acc = 0;
    n_rsp = 0;
    for (int c = 0; c < 14; c++) begin
      req_a = {$urandom(), $urandom()};
      req_b = {$urandom(), $urandom()};
      req_valid = (c < 10) ? 4'hF : 4'h0;
      rsp_ready = (c >= 3 && c < 8) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (c >= 3 && c < 8) begin
        checks += 3;
        if (req_ready !== 4'b0) begin
          failures++; $display("FAIL bp_ready cyc=%0d got=%b required 0000", c, req_ready);
        end
        if (rsp_valid !== 1'b1) begin
          failures++; $display("FAIL bp_valid cyc=%0d got=%b required 1", c, rsp_valid);
        end
        if (sb.size() == 0 || rsp_c !== sb[0].c || rsp_id !== sb[0].id) begin
          failures++;
          $display("FAIL bp_frozen cyc=%0d got id=%0d c=%h required head of %0d pending",
                   c, rsp_id, rsp_c, sb.size());
        end
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    drain("bp");
    checks += 2;
    if (n_acc != 5) begin failures++; $display("FAIL bp_accepts got=%0d required 5", n_acc); end
    if (n_rsp != n_acc) begin failures++; $display("FAIL bp_count got=%0d required %0d", n_rsp, n_acc); end
  endtask

  task automatic test_reset_mid;
    int seen;
    test_reset();
    req_a = 64'h0000_0000_0009_0005;
    req_b = 64'h0000_0000_0007_0006;
    req_valid = 4'b0001;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL rmid_ready0 got=%b required 0001", req_ready); end
    @(posedge clk); #1 req_valid = 4'b0010;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin failures++; $display("FAIL rmid_ready1 got=%b required 0010", req_ready); end
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = '0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks += 2;
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b required 0", rsp_valid); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b required 0", busy); end
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL rmid_stale got=%0d responses required 0", seen); end
    @(posedge clk); #1;
  endtask

`ifdef MULT_ARB_CHAIN_EN
  task automatic test_chain;
    test_reset();
    req_a = '0;
    req_b = '0;
    req_a[47:32] = 16'h0100;
    req_b[47:32] = 16'h0101;
    req_chain = 4'b0100;
    req_valid = 4'b0100;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin failures++; $display("FAIL chain_ready got=%b required 0100", req_ready); end
    @(posedge clk); #1;
    req_chain = '0;
    req_a[15:0] = 16'h0002;
    req_b[15:0] = 16'h0003;
    req_valid = 4'b0001;
    @(negedge clk);
    checks += 2;
    if (req_ready !== 4'b0000) begin failures++; $display("FAIL chain_defer got=%b required 0000", req_ready); end
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL chain_t1 got=%b required 0", rsp_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    checks += 2;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL chain_retry got=%b required 0001", req_ready); end
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL chain_bubble got=%b required 0", rsp_valid); end
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    checks += 3;
    if (rsp_valid !== 1'b1) begin failures++; $display("FAIL chain_valid got=%b required 1", rsp_valid); end
    if (rsp_c !== 32'h00000100) begin failures++; $display("FAIL chain_c got=%h required 00000100", rsp_c); end
    if (rsp_id !== 2'd2) begin failures++; $display("FAIL chain_id got=%0d required 2", rsp_id); end
    @(posedge clk); #1;
    @(negedge clk);
    checks += 2;
    if (rsp_c !== 32'h00000006) begin failures++; $display("FAIL chain_next_c got=%h required 00000006", rsp_c); end
    if (rsp_id !== 2'd0) begin failures++; $display("FAIL chain_next_id got=%0d required 0", rsp_id); end
    @(posedge clk); #1;
    drain("chain");
  endtask
`endif

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_signs();
    test_fairness();
    test_backpressure();
    test_reset_mid();
`ifdef MULT_ARB_CHAIN_EN
    test_chain();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mult_16_signed_arbiter.md
# mult_16_signed_arbiter

Round-robin scheduler that shares one pipelined 16x16 signed multiplier among `NREQ` requesters. Each requester presents an operand pair through a valid/ready handshake. The block grants one requester per cycle, tags the operation with the requester index and returns the 32-bit signed product on a single response port with backpressure. It sits between the compute clients and the shared multiplier resource, so the multiplier is instantiated once rather than per client.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters; legal values are 2 to 8.
- `LAT`, default 2: cycles from acceptance to `rsp_valid`, including the output register; must be at least 2.

Ports:
- `clk`  input  1: single clock; all logic is on the rising edge.
- `rst`  input  1: reset, synchronous, active-high.
- `req_valid`  input  NREQ: bit i means requester i holds an operand pair.
- `req_ready`  output  NREQ: bit i means requester i's pair is accepted this cycle; one-hot or zero.
- `req_a`  input  NREQ*16: signed operand a; requester i uses bits [16i+15:16i].
- `req_b`  input  NREQ*16: signed operand b; same packing as `req_a`.
- `req_chain`  input  NREQ: per-requester chain request; present only with `MULT_ARB_CHAIN_EN`.
- `rsp_valid`  output  1: the response register holds a result.
- `rsp_ready`  input  1: the consumer accepts the response.
- `rsp_id`  output  $clog2(NREQ): index of the requester that owns the result.
- `rsp_c`  output  32: signed product.
- `busy`  output  1: any pipeline stage or the response register is valid.

## Operation
- Pipeline stages 1 to LAT-1 each hold a valid bit, an id, a chain flag and the operands or partial product. Stage LAT is the response register.
- `advance` = !rsp_valid || rsp_ready. When `advance` is 0, the whole pipeline holds and no grant is issued.
- Arbitration:
  - The round-robin pointer `ptr` resets to 0.
  - The grant goes to the first i with `req_valid[i]` set, scanning from `ptr` upward and wrapping at NREQ.
  - On a grant, `ptr` becomes the granted index + 1, modulo NREQ.
  - With no request, `ptr` is unchanged.
- `req_ready[i]` = grant[i] && advance && !reinject. It is combinational from the valid inputs and the current state.
- Arithmetic:
  - Full signed 16x16 to 32 product with no truncation or saturation.
  - -32768 * -32768 = 0x40000000.
- Ordering:
  - Results leave in acceptance order.
  - `rsp_id` and `rsp_c` are stable while `rsp_valid` is high and `rsp_ready` is low.
- Reset values:
  - `rsp_valid`=0, `rsp_c`=0, `rsp_id`=0, `busy`=0, `req_ready`=0.
  - All stage valid bits are 0 and `ptr`=0.
- Reset mid-operation: everything in flight is discarded without a response. Requesters must re-present their pairs.
- Simultaneous response handoff and new grant in the same cycle is allowed; this gives full throughput of one result per cycle.

## Timing
- A pair accepted at edge T produces `rsp_valid` at edge T+LAT when there are no stalls. Each stall cycle adds one cycle.
- Throughput is 1 per cycle with `rsp_ready` held high.
- `req_valid` may drop without acceptance; a dropped request is not remembered.
- `busy` is registered and reflects the state after each edge.

## Configuration
- `MULT_ARB_CHAIN_EN` defined: the block has the `req_chain` port.
  - The chain flag is captured with the grant.
  - A first-pass entry with the flag set, leaving stage LAT-1 on `advance`, does not load the response register.
  - Instead it re-enters stage 1 with a = product[15:0] and b = product[31:16], flag cleared and id kept.
  - That cycle sets `reinject`=1, so no new grant is issued.
  - The chained result appears at T+2*LAT-1.
  - The response register receives a bubble on that edge, so `rsp_valid` is low unless it is holding an earlier result.
- `MULT_ARB_CHAIN_EN` undefined: there is no `req_chain` port, no reinject path, and `reinject` is constant 0.

## Test plan
- Reset, then a single request with LAT=2 on requester 0, a=0x7FFF, b=0x7FFF: accepted at T; `rsp_valid` at T+2 with `rsp_c`=0x3FFF0001 and `rsp_id`=0.
- Sign cases: a=0xFFFF, b=0x8000 gives 0x00008000; a=0x8000, b=0x8000 gives 0x40000000; a=0x0003, b=0xFFFB gives 0xFFFFFFF1.
- Fairness: all 4 requesters hold valid for 8 cycles. Grants must run 0,1,2,3,0,1,2,3 and responses return in the same id order, one per cycle.
- Backpressure: `rsp_ready` low for 5 cycles while requests stream.
  - No `req_ready` during the stall.
  - `rsp_c` and `rsp_id` stay frozen.
  - No result is lost or duplicated after release.
- Reset mid-operation: assert `rst` with 2 entries in flight. The next cycle has `rsp_valid`=0 and `busy`=0, and no stale response follows.
- With `MULT_ARB_CHAIN_EN`, requester 2 sends a=0x0100, b=0x0101 with chain=1.
  - The result is 0x00000100 with id 2 at T+3 for LAT=2.
  - The first-pass value 0x00010100 never appears on `rsp_c` as a valid response.
  - Any request on the reinject cycle is deferred one cycle.
